chip8_system: RTL and testbench



---
 rtl/chip8_pkg.sv | 32 +++
 rtl/chip8_cpu.sv | 149 ++++++++++++++
 rtl/chip8_mem.sv | 36 +++
 rtl/chip8_tick_div.sv | 27 ++
 rtl/chip8_system.sv | 115 +++++++++++
 tb/tb_chip8_system.sv | 213 +++++++++++++++++++++
 6 files changed

// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared types, constants and helpers for the CHIP-8 system
package chip8_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } sys_state_t;

    typedef enum logic [2:0] {
        CPU_FETCH_HI = 3'd0,
        CPU_FETCH_LO = 3'd1,
        CPU_EXEC     = 3'd2,
        CPU_STORE    = 3'd3,
        CPU_DRAW     = 3'd4
    } cpu_state_t;

    localparam int unsigned DEFAULT_LOAD_BASE = 'h200;
    localparam int KEY_W = 16;

    // Hex digit glyphs 0..F, five bytes each, byte 0 in the most significant position.
    localparam logic [639:0] FONT = {
        40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
        40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
        40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
        40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
    };

    function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/chip8_cpu.sv
// rtl/chip8_cpu.sv - compact multi-cycle CHIP-8 core with timer tick input and store strobe
module chip8_cpu
    import chip8_pkg::*;
#(
    parameter int          AW     = 12,
    parameter int unsigned START  = DEFAULT_LOAD_BASE,
    parameter int          DISP_W = 64,
    parameter int          DISP_H = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [KEY_W-1:0]         keys,
    input  logic                     timer_tick,
    output logic [AW-1:0]            mem_addr_out,
    input  logic [7:0]               mem_data_in,
    output logic [7:0]               mem_data_out,
    output logic                     mem_we,
    output logic [DISP_W*DISP_H-1:0] display
);

    localparam int PW = $clog2(DISP_W * DISP_H);

    cpu_state_t state, state_next;
    logic [AW-1:0] pc, idx_reg;
    logic [15:0]   ir;
    logic [7:0]    v [16];
    logic [7:0]    delay_timer, sound_timer;
    logic [3:0]    step;
    logic [3:0]    x, y, n;
    logic [7:0]    nn;
    logic [DISP_W*DISP_H-1:0] fb;

    assign x       = ir[11:8];
    assign y       = ir[7:4];
    assign n       = ir[3:0];
    assign nn      = ir[7:0];
    assign display = fb;

    function automatic logic [PW-1:0] pix_index(input logic [7:0] px, input logic [7:0] py,
                                                input int c, input logic [3:0] r);
        return PW'(((int'(px) + c) % DISP_W) + ((int'(py) + int'(r)) % DISP_H) * DISP_W);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CPU_FETCH_HI;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CPU_FETCH_HI: state_next = CPU_FETCH_LO;
            CPU_FETCH_LO: state_next = CPU_EXEC;
            CPU_EXEC: begin
                if (ir[15:12] == 4'hF && nn == 8'h55) begin
                    state_next = CPU_STORE;
                end else if (ir[15:12] == 4'hD && n != 4'd0) begin
                    state_next = CPU_DRAW;
                end else begin
                    state_next = CPU_FETCH_HI;
                end
            end
            CPU_STORE: if (step == x) state_next = CPU_FETCH_HI;
            CPU_DRAW:  if (step == n - 4'd1) state_next = CPU_FETCH_HI;
            default:   state_next = CPU_FETCH_HI;
        endcase
    end

    always_comb begin
        mem_addr_out = pc;
        mem_we       = 1'b0;
        mem_data_out = v[step];
        case (state)
            CPU_FETCH_LO: mem_addr_out = pc + 1'b1;
            CPU_STORE: begin
                mem_addr_out = idx_reg + AW'(step);
                mem_we       = 1'b1;
            end
            CPU_DRAW:  mem_addr_out = idx_reg + AW'(step);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= AW'(START);
            idx_reg     <= '0;
            ir          <= '0;
            step        <= '0;
            delay_timer <= '0;
            sound_timer <= '0;
            fb          <= '0;
            for (int i = 0; i < 16; i++) v[i] <= '0;
        end else begin
            if (timer_tick) begin
                if (delay_timer != 8'd0) delay_timer <= delay_timer - 8'd1;
                if (sound_timer != 8'd0) sound_timer <= sound_timer - 8'd1;
            end
            case (state)
                CPU_FETCH_HI: ir[15:8] <= mem_data_in;
                CPU_FETCH_LO: begin
                    ir[7:0] <= mem_data_in;
                    pc      <= pc + AW'(2);
                    step    <= '0;
                end
                CPU_EXEC: begin
                    case (ir[15:12])
                        4'h0: if (ir == 16'h00E0) fb <= '0;
                        4'h1: pc <= AW'(ir[11:0]);
                        4'h3: if (v[x] == nn) pc <= pc + AW'(2);
                        4'h4: if (v[x] != nn) pc <= pc + AW'(2);
                        4'h6: v[x] <= nn;
                        4'h7: v[x] <= v[x] + nn;
                        4'hA: idx_reg <= AW'(ir[11:0]);
                        4'hD: v[15] <= 8'h00;
                        4'hE: if ((nn == 8'h9E && keys[v[x][3:0]]) ||
                                  (nn == 8'hA1 && !keys[v[x][3:0]])) pc <= pc + AW'(2);
                        4'hF: begin
                            case (nn)
                                8'h07: v[x] <= delay_timer;
                                8'h15: delay_timer <= v[x];
                                8'h18: sound_timer <= v[x];
                                8'h1E: idx_reg <= idx_reg + AW'(v[x]);
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase
                end
                CPU_STORE: step <= step + 4'd1;
                CPU_DRAW: begin
                    // One sprite row per cycle; XOR into the framebuffer and flag collisions in VF.
                    for (int c = 0; c < 8; c++) begin
                        if (mem_data_in[7-c]) begin
                            if (fb[pix_index(v[x], v[y], c, step)]) v[15] <= 8'h01;
                            fb[pix_index(v[x], v[y], c, step)] <= ~fb[pix_index(v[x], v[y], c, step)];
                        end
                    end
                    step <= step + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/chip8_mem.sv
// rtl/chip8_mem.sv - byte memory with one write port and a font ROM overlay
module chip8_mem
    import chip8_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    data_in,
    output logic [7:0]    data_out
);

    logic [7:0]    ram [2**AW];
    logic [1023:0] font_bits;
    logic [6:0]    font_idx;

    assign font_bits = {384'd0, FONT};
    assign font_idx  = 7'd79 - addr[6:0];

    always_ff @(posedge clk) begin
        if (we) begin
            ram[addr] <= data_in;
        end
    end

    // The glyph region always reads from ROM, so it survives any reset or stray write.
    always_comb begin
        if (int'(addr) < 80) begin
            data_out = font_bits[{font_idx, 3'b000} +: 8];
        end else begin
            data_out = ram[addr];
        end
    end

endmodule

// File: rtl/chip8_tick_div.sv
// rtl/chip8_tick_div.sv - clock divider producing the one-cycle timer tick
module chip8_tick_div #(
    parameter int DIV = 16666
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            count <= '0;
        end else if (count == CW'(DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = en && (count == CW'(DIV - 1));

endmodule

// File: rtl/chip8_system.sv
// rtl/chip8_system.sv - CHIP-8 top: program loader, memory arbiter and timer tick divider
module chip8_system
    import chip8_pkg::*;
#(
    parameter int          MEM_AW    = 12,
    parameter int unsigned LOAD_BASE = DEFAULT_LOAD_BASE,
    parameter int          DISP_W    = 64,
    parameter int          DISP_H    = 32,
    parameter int          CLK_HZ    = 1000000,
    parameter int          TICK_HZ   = 60
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [KEY_W-1:0]         keys,
    input  logic                     load_valid,
    input  logic [7:0]               load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic                     running,
    output logic                     load_err,
    output logic [MEM_AW-1:0]        load_count,
    output logic                     timer_tick,
    output logic [DISP_W*DISP_H-1:0] display
);

    localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);

    sys_state_t state, state_next;
    logic [MEM_AW-1:0] load_addr, mem_addr, cpu_addr;
    logic [7:0]        mem_wdata, mem_rdata, cpu_wdata, cpu_rdata;
    logic              mem_we, cpu_we, cpu_reset, handshake, at_top;

    assign load_addr = MEM_AW'(LOAD_BASE) + load_count;
    assign handshake = load_valid && load_ready;
    assign at_top    = (load_addr == '1);
    assign cpu_reset = reset || !running;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_next;
        end
    end

    // Leaving LOAD on the top byte stops the address from ever wrapping into low memory.
    always_comb begin
        state_next = state;
        if (state == ST_LOAD && handshake && (load_last || at_top)) begin
            state_next = ST_RUN;
        end
    end

    always_comb begin
        load_ready = (state == ST_LOAD);
        running    = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_count <= '0;
            load_err   <= 1'b0;
        end else if (state == ST_LOAD && handshake) begin
            load_count <= load_count + 1'b1;
            if (at_top && !load_last) load_err <= 1'b1;
        end
    end

    always_comb begin
        if (state == ST_LOAD) begin
            mem_we    = handshake && !reset;
            mem_addr  = load_addr;
            mem_wdata = load_data;
            cpu_rdata = 8'h00;
        end else begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            cpu_rdata = mem_rdata;
        end
    end

    chip8_mem #(.AW(MEM_AW)) u_mem (
        .clk      (clk),
        .we       (mem_we),
        .addr     (mem_addr),
        .data_in  (mem_wdata),
        .data_out (mem_rdata)
    );

    chip8_tick_div #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .tick  (timer_tick)
    );

    chip8_cpu #(
        .AW     (MEM_AW),
        .START  (LOAD_BASE),
        .DISP_W (DISP_W),
        .DISP_H (DISP_H)
    ) u_cpu (
        .clk          (clk),
        .reset        (cpu_reset),
        .keys         (keys),
        .timer_tick   (timer_tick),
        .mem_addr_out (cpu_addr),
        .mem_data_in  (cpu_rdata),
        .mem_data_out (cpu_wdata),
        .mem_we       (cpu_we),
        .display      (display)
    );

endmodule

// File: tb/tb_chip8_system.sv
// tb/tb_chip8_system.sv - self-checking bench for chip8_system loader, arbiter and tick
module tb_chip8_system;
    import chip8_pkg::*;

    localparam int AW = 12;
    localparam int LB = 'h200;
    localparam int DW = 64;
    localparam int DH = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [15:0]       keys = 16'h0000;
    logic              load_valid = 1'b0;
    logic [7:0]        load_data = 8'h00;
    logic              load_last = 1'b0;
    logic              load_ready, running, load_err, timer_tick;
    logic [AW-1:0]     load_count;
    logic [DW*DH-1:0]  display;

    int checks = 0;
    int passes = 0;
    int wr_count = 0;
    int low_wr = 0;

    logic [7:0] model_mem [2**AW];
    int model_count = 0;
    bit model_run = 1'b0;
    bit model_err = 1'b0;

    chip8_system #(
        .MEM_AW(AW), .LOAD_BASE(LB), .DISP_W(DW), .DISP_H(DH), .CLK_HZ(600), .TICK_HZ(60)
    ) dut (
        .clk(clk), .reset(reset), .keys(keys),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .running(running), .load_err(load_err),
        .load_count(load_count), .timer_tick(timer_tick), .display(display)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dut.mem_we) begin
            wr_count++;
            if (int'(dut.mem_addr) < LB) low_wr++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        model_count = 0;
        model_run = 1'b0;
        model_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        if (!model_run) begin
            model_mem[LB + model_count] = d;
            if (last || (LB + model_count == 2**AW - 1)) begin
                model_run = 1'b1;
                model_err = !last;
            end
            model_count++;
        end
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        int w0, l0, a, exp_delay;

        keys = 16'($urandom);
        step();
        step();
        check("rst_running", running, 1'b0);
        check("rst_ready", load_ready, 1'b1);
        check("rst_count", load_count, 0);
        check("rst_err", load_err, 1'b0);
        check("rst_tick", timer_tick, 1'b0);
        check("rst_display_zero", {63'd0, display === '0}, 64'd1);
        reset = 1'b0;

        // four-byte program, last flagged on the fourth
        w0 = wr_count;
        send_byte(8'h12, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hAA, 1'b0);
        check("t1_tick_in_load", timer_tick, 1'b0);
        check("t1_not_running", running, 1'b0);
        send_byte(8'h55, 1'b1);
        check("t1_running", running, 1'b1);
        check("t1_ready_low", load_ready, 1'b0);
        check("t1_count", load_count, model_count);
        check("t1_writes", wr_count - w0, 4);
        for (int i = 0; i < 4; i++) check("t1_mem", dut.u_mem.ram[LB + i], model_mem[LB + i]);

        // tick every 10th running cycle; loader bytes offered in RUN are ignored
        for (int c = 1; c <= 35; c++) begin
            check("tick_cycle", timer_tick, (c % 10 == 0));
            if (c == 12) begin
                load_valid = 1'b1;
                load_data  = 8'hEE;
            end
            step();
        end
        load_valid = 1'b0;
        check("run_ignore_count", load_count, 4);
        check("run_ignore_writes", wr_count - w0, 4);

        // reset during RUN with a byte offered, held one more cycle into LOAD
        w0 = wr_count;
        reset = 1'b1;
        load_valid = 1'b1;
        load_data = 8'h77;
        step();
        check("rr_running", running, 1'b0);
        check("rr_count", load_count, 0);
        check("rr_err", load_err, 1'b0);
        check("rr_divider", dut.u_tick.count, 0);
        check("rr_tick", timer_tick, 1'b0);
        step();
        check("rr_no_write", wr_count - w0, 0);
        check("rr_count_held", load_count, 0);
        for (int i = 0; i < 4; i++) check("rr_mem_intact", dut.u_mem.ram[LB + i], model_mem[LB + i]);
        load_valid = 1'b0;
        reset = 1'b0;
        model_count = 0;
        model_run = 1'b0;

        // valid every third cycle, six bytes
        w0 = wr_count;
        for (int i = 0; i < 6; i++) begin
            send_byte(8'($urandom), 1'b0);
            step();
            step();
        end
        check("t2_count", load_count, 6);
        check("t2_writes", wr_count - w0, 6);
        check("t2_running", running, 1'b0);
        for (int i = 0; i < 6; i++) check("t2_mem", dut.u_mem.ram[LB + i], model_mem[LB + i]);
        do_reset();

        // overflow: 3585 bytes, no last; program starts with a self-jump
        w0 = wr_count;
        l0 = low_wr;
        for (int i = 0; i < 3585; i++) begin
            send_byte(i == 0 ? 8'h12 : (i == 1 ? 8'h00 : 8'($urandom)), 1'b0);
            if (i == 3582) check("ov_not_yet", running, 1'b0);
            if (i == 3583) begin
                check("ov_running", running, 1'b1);
                check("ov_err", load_err, 1'b1);
            end
        end
        check("ov_err_sticky", load_err, model_err);
        check("ov_count", load_count, model_count);
        check("ov_writes", wr_count - w0, 3584);
        check("ov_low_writes", low_wr - l0, 0);
        check("ov_mem_base", dut.u_mem.ram[LB], model_mem[LB]);
        check("ov_mem_top", dut.u_mem.ram[2**AW - 1], model_mem[2**AW - 1]);
        for (int i = 0; i < 4; i++) begin
            a = LB + int'($urandom_range(0, 3583));
            check("ov_mem_rand", dut.u_mem.ram[a], model_mem[a]);
        end
        do_reset();

        // exact fit: last flagged on the top byte
        for (int i = 0; i < 3584; i++)
            send_byte(i == 0 ? 8'h12 : (i == 1 ? 8'h00 : 8'($urandom)), i == 3583);
        check("fit_running", running, 1'b1);
        check("fit_err", load_err, 1'b0);
        check("fit_count", load_count, model_count);
        do_reset();

        // 6005 F015 1204: delay timer loaded with 5 then counted down by ticks
        send_byte(8'h60, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h15, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h04, 1'b1);
        check("dly_running", running, 1'b1);
        for (int c = 1; c <= 62; c++) begin
            exp_delay = 5 - (c - 1) / 10;
            if (exp_delay < 0) exp_delay = 0;
            if (c == 9 || (c % 10 == 1 && c > 1))
                check("dly_value", dut.u_cpu.delay_timer, exp_delay);
            step();
        end
        check("dly_zero_final", dut.u_cpu.delay_timer, 0);
        check("dly_display_zero", {63'd0, display === '0}, 64'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
